cnt_bus_rd_arbiter: RTL and testbench

// - Shares the single read port of the controller BRAM among NUM_REQ requesters: the

---
 rtl/cnt_bus_rd_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cnt_bus_rd_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_bus_rd_arbiter.sv
// Read-port arbiter for the controller BRAM: registered grant, optional lock ownership, in-order tagged returns.
// Build option: define CNT_BUS_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round robin.
module cnt_bus_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ-1:0]             LOCK,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  ADDR,
  output logic [NUM_REQ-1:0]             GNT,
  output logic [NUM_REQ-1:0]             RVALID,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic                           BUS_EN,
  output logic [ADDR_WIDTH-1:0]          BUS_ADDR,
  input  logic [DATA_WIDTH-1:0]          BUS_DOUT
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {IDLE, OWNED} state_t;

  state_t state_q, state_d;
  idx_t   owner_q, owner_d;
  logic   gnt_vld;
  idx_t   gnt_idx;
  logic [NUM_REQ-1:0] gnt_vec;

  logic [NUM_REQ-1:0]    gnt_p0;
  logic                  vld_p0;
  idx_t                  tag_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;

  logic vld_p [1:RD_LATENCY];
  idx_t tag_p [1:RD_LATENCY];

  logic [NUM_REQ-1:0]    rvalid_pout;
  logic [DATA_WIDTH-1:0] rdata_pout;

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifndef CNT_BUS_ARB_FIXED_PRIO_EN
  idx_t rr_ptr_q, rr_ptr_d;

  function automatic idx_t wrap_idx(input idx_t base, input int off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + (IDX_W+1)'(off);
    if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
    return s[IDX_W-1:0];
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_vld = 1'b0;
    gnt_idx = owner_q;
`ifndef CNT_BUS_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef CNT_BUS_ARB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (REQ[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx_t'(k);
          end
        end
`else
        // Scan offsets high to low so the candidate nearest rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (REQ[wrap_idx(rr_ptr_q, k)]) begin
            gnt_vld = 1'b1;
            gnt_idx = wrap_idx(rr_ptr_q, k);
          end
        end
        if (gnt_vld) begin
          rr_ptr_d = (gnt_idx == idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
`endif
        if (gnt_vld && LOCK[gnt_idx]) begin
          state_d = OWNED;
          owner_d = gnt_idx;
        end
      end
      OWNED: begin
        gnt_vld = REQ[owner_q];
        gnt_idx = owner_q;
        if (!LOCK[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_vec = '0;
    if (gnt_vld) gnt_vec = onehot(gnt_idx);
  end

  // Stage p0: grant issued to the BRAM
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
`ifndef CNT_BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
      gnt_p0  <= '0;
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifndef CNT_BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
      gnt_p0  <= gnt_vec;
      vld_p0  <= gnt_vld;
      if (gnt_vld) addr_p0 <= ADDR[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    tag_p0 <= gnt_idx;
  end

  // Stages p1..pRD_LATENCY: requester tag follows the read through the BRAM
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 1; k <= RD_LATENCY; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[1] <= vld_p0;
      for (int k = 2; k <= RD_LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    tag_p[1] <= tag_p0;
    for (int k = 2; k <= RD_LATENCY; k++) tag_p[k] <= tag_p[k-1];
  end

  // Return stage: BUS_DOUT is valid alongside the last tag stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid_pout <= '0;
      rdata_pout  <= '0;
    end else begin
      rvalid_pout <= vld_p[RD_LATENCY] ? onehot(tag_p[RD_LATENCY]) : '0;
      if (vld_p[RD_LATENCY]) rdata_pout <= BUS_DOUT;
    end
  end

  assign GNT      = gnt_p0;
  assign BUS_EN   = vld_p0;
  assign BUS_ADDR = addr_p0;
  assign RVALID   = rvalid_pout;
  assign RDATA    = rdata_pout;

endmodule

// File: tb/tb_cnt_bus_rd_arbiter.sv
// Directed bench for cnt_bus_rd_arbiter with a BRAM model and a return scoreboard.
module tb_cnt_bus_rd_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, lock;
  logic [NR*AW-1:0]  addr;
  logic [NR-1:0]     gnt, rvalid;
  logic [DW-1:0]     rdata, bus_dout;
  logic              bus_en;
  logic [AW-1:0]     bus_addr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  logic [AW-1:0] last_addr;

  typedef struct {
    int            due;
    logic [NR-1:0] vec;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  cnt_bus_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .LOCK(lock), .ADDR(addr),
    .GNT(gnt), .RVALID(rvalid), .RDATA(rdata),
    .BUS_EN(bus_en), .BUS_ADDR(bus_addr), .BUS_DOUT(bus_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {~a, a} ^ 16'h5A3C;
  endfunction

  // BRAM model: data appears LAT cycles after the enable cycle
  logic [DW-1:0] bram_p [LAT];
  always @(posedge clk) begin
    if (bus_en) bram_p[0] <= mem_f(bus_addr);
    for (int k = 1; k < LAT; k++) bram_p[k] <= bram_p[k-1];
  end
  assign bus_dout = bram_p[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic expect_gnt(input string tag, input logic [NR-1:0] vec,
                            input logic [AW-1:0] a, input bit track);
    chk({tag, "_gnt"}, 32'(gnt), 32'(vec));
    chk({tag, "_en"}, 32'(bus_en), 32'(|vec));
    if (vec != '0) begin
      chk({tag, "_addr"}, 32'(bus_addr), 32'(a));
      last_addr = a;
      if (track) sb.push_back('{cyc + LAT + 1, vec, mem_f(a)});
    end else begin
      chk({tag, "_addr_hold"}, 32'(bus_addr), 32'(last_addr));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      expect_gnt("idle", '0, '0, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},   32'(gnt),      32'h0);
    chk({tag, "_en"},    32'(bus_en),   32'h0);
    chk({tag, "_addr"},  32'(bus_addr), 32'h0);
    chk({tag, "_rdata"}, 32'(rdata),    32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("rvalid", 32'(rvalid), 32'(sb[0].vec));
        chk("rdata",  32'(rdata),  32'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        chk("rvalid_quiet", 32'(rvalid), 32'h0);
      end
    end
  end

  initial begin
    logic [AW-1:0] rr_a [NR];
    rr_a = '{8'h40, 8'h51, 8'h62, 8'h73};
    rst = 1'b1; req = '0; lock = '0; addr = '0; last_addr = '0;
    tick();
    tick();
    mon_en = 1'b1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // single requester
    req = 4'b0010; set_addr(1, 8'h10);
    tick();
    expect_gnt("single", 4'b0010, 8'h10, 1'b1);
    req = '0;
    idle(5);
    chk("rdata_hold", 32'(rdata), 32'(mem_f(8'h10)));

`ifdef CNT_BUS_ARB_FIXED_PRIO_EN
    req = 4'b1010; set_addr(1, 8'h61); set_addr(3, 8'h83);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_gnt("fixed", 4'b0010, 8'h61, 1'b1);
    end
    req = '0;
    idle(5);
`else
    // fresh reset so round robin starts at 0
    rst = 1'b1;
    tick();
    check_reset_outputs("reset2");
    last_addr = '0;
    rst = 1'b0;

    req = 4'b1111;
    for (int i = 0; i < NR; i++) set_addr(i, rr_a[i]);
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_gnt("rr", 4'(1 << (k % NR)), rr_a[k % NR], 1'b1);
    end
    req = '0;
    tick();
    expect_gnt("rr_end", '0, '0, 1'b0);

    // lock stream by requester 2 while 0 waits; LOCK[1] from a non-owner
    req = 4'b0101; lock = 4'b0110; set_addr(2, 8'h20); set_addr(0, 8'h05);
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_gnt("lock", 4'b0100, 8'(32'h20 + k), 1'b1);
      if (k < 7) begin
        set_addr(2, 8'(32'h21 + k));
        lock[2] = (k < 6);
      end else begin
        req[2] = 1'b0;
        lock = '0;
      end
    end
    tick();
    expect_gnt("after_lock", 4'b0001, 8'h05, 1'b1);
    req = '0;
    idle(4);

    // owner pause
    req = 4'b1000; lock = 4'b1000; set_addr(3, 8'h30); set_addr(1, 8'h11);
    tick();
    expect_gnt("own3", 4'b1000, 8'h30, 1'b1);
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_gnt("pause", '0, '0, 1'b0);
    end
    req = 4'b1010; lock = '0; set_addr(3, 8'h31);
    tick();
    expect_gnt("resume", 4'b1000, 8'h31, 1'b1);
    req = 4'b0010;
    tick();
    expect_gnt("post_own", 4'b0010, 8'h11, 1'b1);
    req = '0;
    idle(4);

    // reset right after a grant kills that read
    req = 4'b0001; set_addr(0, 8'h0A);
    tick();
    expect_gnt("killed", 4'b0001, 8'h0A, 1'b0);
    rst = 1'b1; req = '0;
    tick();
    check_reset_outputs("midreset");
    last_addr = '0;
    rst = 1'b0;
    req = 4'b0011; set_addr(0, 8'h0B); set_addr(1, 8'h1C);
    tick();
    expect_gnt("rr_restart", 4'b0001, 8'h0B, 1'b1);
    tick();
    expect_gnt("rr_next", 4'b0010, 8'h1C, 1'b1);
    req = '0;
    idle(6);
`endif

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
